// File: rtl/arb_pkg.sv
// Shared types and default sizing for the request arbiter and its winner picker.
package arb_pkg;

   typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_t;
   typedef enum logic {IDLE, BUSY} arb_state_t;

   localparam int DEF_NUM_REQ  = 4;
   localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/req_arbiter_if.sv
// Request/grant bundle between the requesters (master side) and the arbiter (slave side).
interface req_arbiter_if import arb_pkg::*; #(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int MAX_HOLD = DEF_MAX_HOLD
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int HCW = $clog2(MAX_HOLD);

   logic [NUM_REQ-1:0] req;
   logic               rr_mode;
   logic [NUM_REQ-1:0] gnt;
   logic [IDW-1:0]     gnt_id;
   logic               gnt_valid;
   logic [HCW-1:0]     hold_cnt;

   modport master (
      output req, rr_mode,
      input  gnt, gnt_id, gnt_valid, hold_cnt
   );

   modport slave (
      input  req, rr_mode,
      output gnt, gnt_id, gnt_valid, hold_cnt
   );

endinterface

// File: rtl/arb_pick.sv
// Combinational winner selection: highest set index (fixed) or first set bit after last_id (round-robin).
module arb_pick import arb_pkg::*; #(
   parameter int  NUM_REQ = DEF_NUM_REQ,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] cand,
   input  arb_mode_t          mode,
   input  logic [IDW-1:0]     last_id,
   output logic               found,
   output logic [IDW-1:0]     win_id,
   output logic [NUM_REQ-1:0] win_onehot
);

   logic [IDW-1:0] idx;

   // Scans run so the last matching assignment is the winner; NUM_REQ is a power
   // of two, so truncating last_id+k to IDW bits gives the modulo wrap for free.
   always_comb begin
      found  = |cand;
      win_id = '0;
      idx    = '0;
      if (mode == ARB_FIXED) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (cand[i]) win_id = IDW'(i);
         end
      end else begin
         for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last_id + IDW'(k);
            if (cand[idx]) win_id = idx;
         end
      end
      win_onehot         = '0;
      win_onehot[win_id] = found;
   end

endmodule

// File: rtl/req_arbiter.sv
// Registered NUM_REQ-way arbiter with fixed/round-robin modes, held grants and a hold timer.
module req_arbiter import arb_pkg::*; #(
   parameter int  NUM_REQ  = DEF_NUM_REQ,
   parameter int  MAX_HOLD = DEF_MAX_HOLD,
   localparam int IDW      = $clog2(NUM_REQ),
   localparam int HCW      = $clog2(MAX_HOLD)
) (
   input logic          clk,
   input logic          rst,
   req_arbiter_if.slave bus
);

   localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD - 1);

   arb_state_t         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IDW-1:0]     gnt_id_q, gnt_id_d;
   logic [HCW-1:0]     hold_cnt_q, hold_cnt_d;
   logic [IDW-1:0]     last_id_q, last_id_d;

   logic [NUM_REQ-1:0] owner_oh;
   logic [NUM_REQ-1:0] cand;
   logic               found;
   logic [IDW-1:0]     win_id;
   logic [NUM_REQ-1:0] win_onehot;
   logic               take_win;

   arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .cand       (cand),
      .mode       (arb_mode_t'(bus.rr_mode)),
      .last_id    (last_id_q),
      .found      (found),
      .win_id     (win_id),
      .win_onehot (win_onehot)
   );

   // While BUSY the current owner is masked out, so any winner is a handover target.
   always_comb begin
      owner_oh           = '0;
      owner_oh[gnt_id_q] = 1'b1;
      cand               = (state_q == IDLE) ? bus.req : (bus.req & ~owner_oh);
      state_d            = state_q;
      gnt_d              = gnt_q;
      gnt_id_d           = gnt_id_q;
      hold_cnt_d         = hold_cnt_q;
      last_id_d          = last_id_q;
      take_win           = 1'b0;
      case (state_q)
         IDLE: take_win = found;
         BUSY: begin
            if (!bus.req[gnt_id_q]) begin
               take_win = found;
               if (!found) begin
                  state_d    = IDLE;
                  gnt_d      = '0;
                  hold_cnt_d = '0;
               end
            end else if (hold_cnt_q == HOLD_MAX && found) begin
               take_win = 1'b1;
            end else if (hold_cnt_q != HOLD_MAX) begin
               hold_cnt_d = hold_cnt_q + HCW'(1);
            end
         end
         default: ;
      endcase
      if (take_win) begin
         state_d    = BUSY;
         gnt_d      = win_onehot;
         gnt_id_d   = win_id;
         last_id_d  = win_id;
         hold_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         gnt_id_q   <= '0;
         hold_cnt_q <= '0;
         last_id_q  <= IDW'(NUM_REQ - 1);
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         hold_cnt_q <= hold_cnt_d;
         last_id_q  <= last_id_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.gnt_valid = |gnt_q;
   assign bus.hold_cnt  = hold_cnt_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Self-checking bench for req_arbiter: directed scenarios plus random traffic against an integer-level model.
module tb_req_arbiter;
   import arb_pkg::*;

   localparam int NR = 4;
   localparam int MH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   // Reference model state: owner index (-1 when idle), reported id, hold count, RR pointer.
   int m_owner = -1;
   int m_gid   = 0;
   int m_hold  = 0;
   int m_last  = NR - 1;

   req_arbiter_if #(.NUM_REQ(NR), .MAX_HOLD(MH)) bus ();

   req_arbiter #(.NUM_REQ(NR), .MAX_HOLD(MH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic int model_pick(input logic [NR-1:0] c, input logic m, input int last);
      if (!m) begin
         for (int i = NR - 1; i >= 0; i--) if (c[i]) return i;
      end else begin
         for (int k = 1; k <= NR; k++) if (c[(last + k) % NR]) return (last + k) % NR;
      end
      return -1;
   endfunction

   function automatic logic [NR-1:0] exp_gnt();
      logic [NR-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   task automatic model_edge(input logic [NR-1:0] r, input logic m, input logic rs);
      logic [NR-1:0] others;
      int w;
      if (rs) begin
         m_owner = -1; m_gid = 0; m_hold = 0; m_last = NR - 1;
         return;
      end
      if (m_owner < 0) begin
         w = model_pick(r, m, m_last);
         if (w >= 0) begin m_owner = w; m_gid = w; m_last = w; m_hold = 0; end
         return;
      end
      others = r;
      others[m_owner] = 1'b0;
      w = model_pick(others, m, m_last);
      if (!r[m_owner] || (m_hold == MH - 1 && w >= 0)) begin
         if (w >= 0) begin m_owner = w; m_gid = w; m_last = w; m_hold = 0; end
         else begin m_owner = -1; m_hold = 0; end
      end else if (m_hold < MH - 1) begin
         m_hold++;
      end
   endtask

   // Drives inputs away from the edge, lets one rising edge happen, then returns at the falling edge.
   task automatic apply_stimulus(input logic [NR-1:0] r, input logic m, input logic rs);
      bus.req     = r;
      bus.rr_mode = m;
      rst         = rs;
      @(posedge clk);
      model_edge(r, m, rs);
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         apply_stimulus(4'b1111, 1'b0, 1'b1);
         checks++;
         if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.hold_cnt !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: gnt=%b valid=%b hold=%0d, expected 0000/0/0", bus.gnt, bus.gnt_valid, bus.hold_cnt);
         end
      end
      apply_stimulus(4'b1111, 1'b0, 1'b0);
      checks++;
      if (bus.gnt !== 4'b1000 || bus.gnt_id !== 2'd3 || bus.gnt_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_first_grant: gnt=%b id=%0d valid=%b, expected 1000/3/1", bus.gnt, bus.gnt_id, bus.gnt_valid);
      end
   endtask

   task automatic test_fixed_priority();
      apply_stimulus(4'b0000, 1'b0, 1'b1);
      apply_stimulus(4'b0110, 1'b0, 1'b0);
      checks++;
      if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2) begin
         failures++;
         $display("[TB] FAIL fixed_pick: gnt=%b id=%0d, expected 0100/2", bus.gnt, bus.gnt_id);
      end
      apply_stimulus(4'b0010, 1'b0, 1'b0);
      checks++;
      if (bus.gnt !== 4'b0010 || bus.gnt_id !== 2'd1 || bus.gnt_valid !== 1'b1 || bus.hold_cnt !== 3'd0) begin
         failures++;
         $display("[TB] FAIL fixed_handover: gnt=%b id=%0d valid=%b hold=%0d, expected 0010/1/1/0", bus.gnt, bus.gnt_id, bus.gnt_valid, bus.hold_cnt);
      end
      apply_stimulus(4'b0000, 1'b0, 1'b0);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== 2'd1) begin
         failures++;
         $display("[TB] FAIL fixed_release: gnt=%b valid=%b id=%0d, expected 0000/0/1", bus.gnt, bus.gnt_valid, bus.gnt_id);
      end
   endtask

   task automatic test_timeout();
      logic [NR-1:0] want;
      apply_stimulus(4'b0000, 1'b0, 1'b1);
      for (int round = 0; round < 3; round++) begin
         want = (round % 2 == 0) ? 4'b1000 : 4'b0001;
         for (int h = 0; h < MH; h++) begin
            apply_stimulus(4'b1001, 1'b0, 1'b0);
            checks++;
            if (bus.gnt !== want || bus.hold_cnt !== 3'(h)) begin
               failures++;
               $display("[TB] FAIL timeout_round%0d_h%0d: gnt=%b hold=%0d, expected %b/%0d", round, h, bus.gnt, bus.hold_cnt, want, h);
            end
         end
      end
   endtask

   task automatic test_round_robin();
      logic [NR-1:0] want;
      apply_stimulus(4'b0000, 1'b1, 1'b1);
      for (int g = 0; g < 5; g++) begin
         want = '0;
         want[g % NR] = 1'b1;
         for (int h = 0; h < MH; h++) begin
            apply_stimulus(4'b1111, 1'b1, 1'b0);
            checks++;
            if (bus.gnt !== want || bus.hold_cnt !== 3'(h)) begin
               failures++;
               $display("[TB] FAIL rr_rotate_g%0d_h%0d: gnt=%b hold=%0d, expected %b/%0d", g, h, bus.gnt, bus.hold_cnt, want, h);
            end
         end
      end
      apply_stimulus(4'b0000, 1'b1, 1'b1);
      apply_stimulus(4'b0001, 1'b1, 1'b0);
      apply_stimulus(4'b0000, 1'b1, 1'b0);
      apply_stimulus(4'b0101, 1'b1, 1'b0);
      checks++;
      if (bus.gnt !== 4'b0100 || bus.gnt_id !== 2'd2) begin
         failures++;
         $display("[TB] FAIL rr_after_0: gnt=%b id=%0d, expected 0100/2", bus.gnt, bus.gnt_id);
      end
      apply_stimulus(4'b0000, 1'b1, 1'b0);
      apply_stimulus(4'b0011, 1'b1, 1'b0);
      checks++;
      if (bus.gnt !== 4'b0001 || bus.gnt_id !== 2'd0) begin
         failures++;
         $display("[TB] FAIL rr_wrap: gnt=%b id=%0d, expected 0001/0", bus.gnt, bus.gnt_id);
      end
   endtask

   task automatic test_back_to_back();
      apply_stimulus(4'b0000, 1'b0, 1'b1);
      apply_stimulus(4'b0010, 1'b0, 1'b0);
      apply_stimulus(4'b0010, 1'b0, 1'b0);
      apply_stimulus(4'b1000, 1'b0, 1'b0);
      checks++;
      if (bus.gnt !== 4'b1000 || bus.gnt_id !== 2'd3 || bus.hold_cnt !== 3'd0 || bus.gnt_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL release_new_req: gnt=%b id=%0d hold=%0d valid=%b, expected 1000/3/0/1", bus.gnt, bus.gnt_id, bus.hold_cnt, bus.gnt_valid);
      end
   endtask

   task automatic test_reset_mid_grant();
      apply_stimulus(4'b0000, 1'b1, 1'b1);
      for (int h = 0; h < 6; h++) apply_stimulus(4'b0100, 1'b1, 1'b0);
      checks++;
      if (bus.gnt !== 4'b0100 || bus.hold_cnt !== 3'd5) begin
         failures++;
         $display("[TB] FAIL mid_grant_setup: gnt=%b hold=%0d, expected 0100/5", bus.gnt, bus.hold_cnt);
      end
      apply_stimulus(4'b0100, 1'b1, 1'b1);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.hold_cnt !== 3'd0 || bus.gnt_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL mid_grant_reset: gnt=%b hold=%0d valid=%b, expected 0000/0/0", bus.gnt, bus.hold_cnt, bus.gnt_valid);
      end
      apply_stimulus(4'b1010, 1'b1, 1'b0);
      checks++;
      if (bus.gnt !== 4'b0010 || bus.gnt_id !== 2'd1) begin
         failures++;
         $display("[TB] FAIL mid_grant_restart: gnt=%b id=%0d, expected 0010/1", bus.gnt, bus.gnt_id);
      end
   endtask

   task automatic test_random();
      logic [NR-1:0] r;
      logic          m;
      logic          rs;
      apply_stimulus(4'b0000, 1'b0, 1'b1);
      m = 1'b0;
      r = '0;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) r = NR'($urandom);
         if ($urandom_range(0, 15) == 0) m = ~m;
         rs = ($urandom_range(0, 99) == 0);
         apply_stimulus(r, m, rs);
         checks++;
         if (bus.gnt !== exp_gnt() || bus.gnt_id !== 2'(m_gid) || bus.hold_cnt !== 3'(m_hold)
             || bus.gnt_valid !== (m_owner >= 0) || !$onehot0(bus.gnt)) begin
            failures++;
            $display("[TB] FAIL random_c%0d: gnt=%b id=%0d hold=%0d valid=%b, expected %b/%0d/%0d/%b",
                     c, bus.gnt, bus.gnt_id, bus.hold_cnt, bus.gnt_valid, exp_gnt(), m_gid, m_hold, (m_owner >= 0));
         end
      end
   endtask

   initial begin
      bus.req     = '0;
      bus.rr_mode = 1'b0;
      @(negedge clk);
      test_reset();
      test_fixed_priority();
      test_timeout();
      test_round_robin();
      test_back_to_back();
      test_reset_mid_grant();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/req_arbiter.md
Name: req_arbiter

Overview:
- Sequential arbiter that shares one resource (bus, encoder datapath, output port) between NUM_REQ requesters.
- Two arbitration modes:
  - Fixed priority: highest index wins, the same ordering as the team's 4-input priority encoder.
  - Round-robin: rotating priority.
- Grants are registered and held until the owner releases.
- A hold timer prevents a fixed-priority owner from starving others indefinitely.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, ≥2.
- MAX_HOLD, 8, max consecutive grant cycles before forced re-arbitration when others are waiting; ≥2.
- IDW, $clog2(NUM_REQ), width of grant index (derived localparam, not overridable).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  request vector, bit i = requester i.
- rr_mode  input  1  0 = fixed priority (highest index first), 1 = round-robin.
- gnt  output  NUM_REQ  one-hot grant, registered.
- gnt_id  output  IDW  binary index of current owner, registered.
- gnt_valid  output  1  high when gnt is nonzero.
- hold_cnt  output  $clog2(MAX_HOLD)  cycles current owner has held, 0 on new grant.

Behaviour:
- Reset (rst=1 at clk edge):
  - gnt=0, gnt_id=0, gnt_valid=0, hold_cnt=0.
  - State=IDLE; rr pointer last_id=NUM_REQ-1, so the first RR search starts at 0.
- rst has priority over all other activity, including mid-grant. The grant drops the cycle after reset is sampled.
- States are IDLE and BUSY.
- IDLE:
  - If req≠0 at edge t: winner is computed combinationally, then gnt/gnt_id/gnt_valid are asserted from edge t, state goes to BUSY, and hold_cnt=0.
  - Latency: request sampled at edge t gives a grant visible after edge t (one registered stage). There is no combinational req→gnt path.
  - If req=0: stay in IDLE with outputs at 0.
- Winner selection:
  - Fixed mode: highest set index of the candidate vector.
  - RR mode: first set bit scanning last_id+1, last_id+2, … with modulo NUM_REQ wrap.
  - last_id updates to the winner on every new grant, in both modes.
  - rr_mode is sampled only at arbitration edges; changes while BUSY do not affect the current owner.
- BUSY, owner o=gnt_id, evaluated at each edge in priority order:
  1. Release (req[o]=0):
     - If req & ~onehot(o) ≠ 0, re-arbitrate among those bits and grant the new winner next cycle with no idle bubble (back-to-back handover); hold_cnt=0.
     - Otherwise go to IDLE and clear gnt/gnt_valid; gnt_id keeps its last value.
  2. Timeout (req[o]=1, hold_cnt==MAX_HOLD-1, others requesting):
     - Forced handover to the winner among req & ~onehot(o); hold_cnt=0.
     - The preempted owner keeps its req high and competes normally later.
  3. Otherwise hold the grant.
     - hold_cnt increments, saturating at MAX_HOLD-1.
     - If no others are requesting at saturation, the owner keeps the grant indefinitely.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt[gnt_id]==1 whenever gnt_valid.
  - A new grant is never issued to a requester whose req bit was 0 at the arbitration edge.
- Simultaneous release by the owner and a new request in the same cycle: the new requester is granted at that edge.
- All-requesters-active in RR mode: grants rotate 0,1,2,3,0… with each owner holding MAX_HOLD cycles.

Decomposition:
- Package arb_pkg:
  - typedef enum logic {ARB_FIXED=1'b0, ARB_RR=1'b1} arb_mode_t;
  - typedef enum logic {IDLE, BUSY} arb_state_t;
  - Default constants DEF_NUM_REQ=4, DEF_MAX_HOLD=8.
- Sub-module arb_pick (combinational, parameter NUM_REQ):
  - Inputs: cand vector, mode, last_id.
  - Outputs: found, win_id, win_onehot.
  - Implements the fixed highest-index scan and the rotated RR scan.
  - Instantiated once in req_arbiter; also reusable standalone.

Test Plan:
1. Reset: drive rst=1 for 2 cycles with req=4'b1111 → gnt=0, gnt_valid=0, hold_cnt=0 throughout; after rst=0, the grant appears after the next edge.
2. Fixed priority: rr_mode=0, req=4'b0110 at edge t → after t gnt=4'b0100, gnt_id=2. Drop req[2] → next edge gnt=4'b0010, gnt_id=1 with no gnt_valid gap. Drop all → gnt=0.
3. Timeout: rr_mode=0, req=4'b1001 held → req3 granted; after 8 grant cycles (hold_cnt reaching 7) gnt=4'b0001. Then 8 cycles later gnt returns to 4'b1000.
4. Round-robin: rr_mode=1, req=4'b1111 from reset → grant order 0,1,2,3,0, each held 8 cycles. With req=4'b0101 and last_id=0, the next winner is 2.
5. Release/new request same edge: owner 1 drops req[1] while req[3] rises in the same cycle → gnt=4'b1000 on the next edge, hold_cnt=0.
6. Reset mid-grant: owner 2 at hold_cnt=5, assert rst one cycle → gnt=0, hold_cnt=0, state IDLE. After release of rst with req=4'b0100 in RR mode, the search restarts from 0 and grants 2.
